id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS-style pipeline, directly downstream of the instruction decoder. It latches the decoder control word, register operands, immediate and register addresses into the EX stage. It also contains load-use hazard detection, which asserts a stall to PC/IF-ID and inserts a bubble, and it honours branch flush and a global hold. A saturating bubble counter supports performance debug.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_pipe_reg.sv | 95 +++++++++
 tb/tb_id_ex_pipe_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-word layout,
// ALU operation encodings and the NOP control word.
package pipe_pkg;

  localparam int CTRL_W         = 14;
  localparam int CTRL_REGWRITE  = 13;
  localparam int CTRL_ALUOP_HI  = 12;
  localparam int CTRL_ALUOP_LO  = 10;
  localparam int CTRL_ALUSRC    = 9;
  localparam int CTRL_REGDST    = 8;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_MEMREAD   = 6;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_MEMTOREG  = 4;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_BRTYPE    = 2;
  localparam int CTRL_JAL       = 1;
  localparam int CTRL_CMPZERO   = 0;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_RTYPE = 3'd5,
    ALU_LUI   = 3'd6,
    ALU_XOR   = 3'd7
  } alu_op_t;

  // All-zero word: no register write, no memory access, no control transfer.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces one bubble. Register $0 never creates a dependency.
module load_use_detect #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_mem_read,
  input  logic               ex_valid,
  input  logic               flush,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_rt_used,
  input  logic [RADDR_W-1:0] ex_rt,
  output logic               stall
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (id_rs == ex_rt) && (id_rs != '0);
  assign rt_hit = id_rt_used && (id_rt == ex_rt) && (id_rt != '0);

  // A flushed ID instruction is discarded anyway, so it must not stall.
  assign stall = ex_mem_read && ex_valid && !flush && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global hold and a saturating bubble counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  input  logic [DATA_W-1:0]  id_pc4_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [DATA_W-1:0]  id_imm_i,
  input  logic [5:0]         id_funct_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic               id_rt_used_i,
  output logic [CTRL_W-1:0]  ex_ctrl_o,
  output logic [DATA_W-1:0]  ex_pc4_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [5:0]         ex_funct_o,
  output logic [RADDR_W-1:0] ex_rs_o,
  output logic [RADDR_W-1:0] ex_rt_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               ex_valid_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  load_use_detect #(.RADDR_W(RADDR_W)) u_hazard (
    .ex_mem_read (ctrl_mem_read(ex_ctrl_o)),
    .ex_valid    (ex_valid_o),
    .flush       (flush_i),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .id_rt_used  (id_rt_used_i),
    .ex_rt       (ex_rt_o),
    .stall       (stall_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_o    <= CTRL_NOP;
      ex_pc4_o     <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_funct_o   <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_valid_o   <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (flush_i) begin
      // Squashed slot: data still loads, the NOP control word makes it harmless.
      ex_ctrl_o    <= CTRL_NOP;
      ex_valid_o   <= 1'b0;
      ex_pc4_o     <= id_pc4_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_funct_o   <= id_funct_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
    end else if (hold_i) begin
      ex_ctrl_o    <= ex_ctrl_o;
    end else if (stall_o) begin
      ex_ctrl_o    <= CTRL_NOP;
      ex_valid_o   <= 1'b0;
      if (bubble_cnt_o != '1)
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end else begin
      ex_ctrl_o    <= id_ctrl_i;
      ex_valid_o   <= 1'b1;
      ex_pc4_o     <= id_pc4_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_funct_o   <= id_funct_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus random traffic, checked
// against a transaction-level model of the EX slot and the bubble counter.
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam int CMAX = 3;

  localparam logic [13:0] W_RTYPE = 14'b1_101_0_1_0_0_0_0_0_0_0_0;
  localparam logic [13:0] W_LW    = 14'b1_000_1_0_0_1_0_1_0_0_0_0;

  logic clk = 0;
  logic rst, hold, flush, rt_used;
  logic [13:0] id_ctrl;
  logic [DW-1:0] pc4, rs_data, rt_data, imm;
  logic [5:0] funct;
  logic [AW-1:0] rs, rt, rd;
  logic [13:0] ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0] ex_funct;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic ex_valid, stall;
  logic [CW-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail = 0;
  logic last_stall;

  // Model of what the EX slot should hold
  typedef struct {
    logic [13:0] ctrl;
    logic [DW-1:0] pc4, rs_data, rt_data, imm;
    logic [5:0] funct;
    logic [AW-1:0] rs, rt, rd;
    logic valid;
    int cnt;
  } slot_t;
  slot_t m;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_ctrl_i(id_ctrl), .id_pc4_i(pc4), .id_rs_data_i(rs_data),
    .id_rt_data_i(rt_data), .id_imm_i(imm), .id_funct_i(funct),
    .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_rt_used_i(rt_used),
    .ex_ctrl_o(ex_ctrl), .ex_pc4_o(ex_pc4), .ex_rs_data_o(ex_rs_data),
    .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm), .ex_funct_o(ex_funct),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .ex_valid_o(ex_valid),
    .stall_o(stall), .bubble_cnt_o(bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A load sitting in EX blocks any ID reader of its non-zero destination.
  function automatic logic model_stall();
    logic dep;
    dep = (rs != 0 && rs == m.rt) || (rt_used && rt != 0 && rt == m.rt);
    return m.valid && m.ctrl[6] && !flush && dep;
  endfunction

  task automatic load_slot(input logic valid);
    m.ctrl = valid ? id_ctrl : 14'd0;
    m.valid = valid;
    m.pc4 = pc4; m.rs_data = rs_data; m.rt_data = rt_data; m.imm = imm;
    m.funct = funct; m.rs = rs; m.rt = rt; m.rd = rd;
  endtask

  task automatic model_edge();
    logic s;
    s = model_stall();
    if (rst) begin
      m = '{ctrl: 0, pc4: 0, rs_data: 0, rt_data: 0, imm: 0, funct: 0,
             rs: 0, rt: 0, rd: 0, valid: 0, cnt: 0};
    end else if (flush) load_slot(1'b0);
    else if (hold) ;
    else if (s) begin
      m.ctrl = 0; m.valid = 0;
      if (m.cnt < CMAX) m.cnt++;
    end else load_slot(1'b1);
  endtask

  task automatic compare_outputs();
    check_eq("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    check_eq("ex_valid", 64'(ex_valid), 64'(m.valid));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m.cnt));
    if (m.valid || rst) begin
      check_eq("ex_pc4", 64'(ex_pc4), 64'(m.pc4));
      check_eq("ex_rs_data", 64'(ex_rs_data), 64'(m.rs_data));
      check_eq("ex_rt_data", 64'(ex_rt_data), 64'(m.rt_data));
      check_eq("ex_imm", 64'(ex_imm), 64'(m.imm));
      check_eq("ex_funct", 64'(ex_funct), 64'(m.funct));
      check_eq("ex_rs", 64'(ex_rs), 64'(m.rs));
      check_eq("ex_rt", 64'(ex_rt), 64'(m.rt));
      check_eq("ex_rd", 64'(ex_rd), 64'(m.rd));
    end
  endtask

  // Inputs are driven at negedge; stall is checked before the edge, registers after.
  task automatic step();
    #1;
    last_stall = model_stall();
    check_eq("stall", 64'(stall), 64'(last_stall));
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [13:0] c, input logic [AW-1:0] a_rs,
                        input logic [AW-1:0] a_rt, input logic [AW-1:0] a_rd,
                        input logic used);
    id_ctrl = c; rs = a_rs; rt = a_rt; rd = a_rd; rt_used = used;
    pc4 = $urandom; rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    funct = 6'($urandom);
  endtask

  function automatic logic [AW-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; hold = 0; flush = 0;
    set_id(14'd0, 0, 0, 0, 0);
    m.cnt = 0;
    @(negedge clk);
    step();
    check_eq("reset_valid", 64'(ex_valid), 64'd0);
    check_eq("reset_ctrl", 64'(ex_ctrl), 64'd0);
    rst = 0;

    // Normal capture
    set_id(W_RTYPE, 5'd1, 5'd2, 5'd5, 1'b1);
    rs_data = 32'h11; rt_data = 32'h22;
    step();
    check_eq("cap_rs_data", 64'(ex_rs_data), 64'h11);
    check_eq("cap_rd", 64'(ex_rd), 64'd5);

    // Load-use on rs: exactly one bubble
    set_id(W_LW, 5'd3, 5'd8, 5'd0, 1'b0);
    step();
    set_id(W_RTYPE, 5'd8, 5'd4, 5'd6, 1'b1);
    step();
    check_eq("lu_stall_seen", 64'(last_stall), 64'd1);
    check_eq("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    step();
    check_eq("lu_resume_valid", 64'(ex_valid), 64'd1);
    check_eq("lu_resume_stall", 64'(last_stall), 64'd0);

    // $0 and rt_used filtering
    set_id(W_LW, 5'd3, 5'd0, 5'd0, 1'b0); step();
    set_id(W_RTYPE, 5'd0, 5'd0, 5'd7, 1'b1); step();
    check_eq("zero_nostall", 64'(last_stall), 64'd0);
    set_id(W_LW, 5'd3, 5'd9, 5'd0, 1'b0); step();
    set_id(W_LW, 5'd4, 5'd9, 5'd0, 1'b0); step();
    check_eq("rt_unused_nostall", 64'(last_stall), 64'd0);
    set_id(W_RTYPE, 5'd4, 5'd9, 5'd7, 1'b1); step();
    check_eq("rt_used_stall", 64'(last_stall), 64'd1);

    // Flush beats hazard and hold
    set_id(W_LW, 5'd3, 5'd8, 5'd0, 1'b0); step();
    set_id(W_RTYPE, 5'd8, 5'd8, 5'd7, 1'b1); flush = 1; hold = 1; step();
    check_eq("flush_stall", 64'(last_stall), 64'd0);
    check_eq("flush_valid", 64'(ex_valid), 64'd0);
    check_eq("flush_cnt", 64'(bubble_cnt), 64'd2);
    flush = 0; hold = 0;

    // Hold for three cycles with changing inputs
    set_id(W_LW, 5'd3, 5'd10, 5'd0, 1'b0); step();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(14'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
      step();
      check_eq("hold_rt", 64'(ex_rt), 64'd10);
    end
    hold = 0;
    set_id(W_RTYPE, 5'd1, 5'd2, 5'd3, 1'b1); step();
    check_eq("hold_release_ctrl", 64'(ex_ctrl), 64'(W_RTYPE));

    // Saturation: five more bubbles
    for (int i = 0; i < 5; i++) begin
      set_id(W_LW, 5'd3, 5'd8, 5'd0, 1'b0); step();
      set_id(W_RTYPE, 5'd8, 5'd1, 5'd2, 1'b1); step();
    end
    check_eq("sat_cnt", 64'(bubble_cnt), 64'd3);

    // Reset in the middle of a stall
    set_id(W_LW, 5'd3, 5'd8, 5'd0, 1'b0); step();
    set_id(W_RTYPE, 5'd8, 5'd1, 5'd2, 1'b1); rst = 1; step();
    check_eq("rst_cnt", 64'(bubble_cnt), 64'd0);
    check_eq("rst_pc4", 64'(ex_pc4), 64'd0);
    rst = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 6) == 0);
      set_id(14'($urandom), pick_reg(), pick_reg(), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) < 4) id_ctrl[6] = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
